frog_hop_ctrl: RTL and testbench
================================

Name: frog_hop_ctrl

Overview:
- Frog movement and scoring controller, directly upstream of the top-level frogger game module.
- Converts player button presses into single-tile hops on the 14x13 tile grid.
- Evaluates landings on the goal row, and keeps score and lives.
- Produces the frog tile position, the per-pixel frog draw flag for the video mux, the score for the 7-segment stage, and the game-active flag.

Parameters:
- c_GAME_WIDTH, 14, tile columns on the grid.
- c_GAME_HEIGHT, 13, tile rows on the grid.
- c_START_X, 7, frog spawn column.
- c_START_Y, 12, frog spawn row (bottom safe row).
- c_HOP_DELAY, 6250000, clocks of hop lockout after each hop (0.25 s at 25 MHz).
- c_LIVES, 3, lives at game start.
- c_SCORE_LIMIT, 99, score that ends the game as a win.

Ports:
- i_Clk  in  1  pixel clock
- i_Rst_N  in  1  asynchronous active-low reset
- i_Game_Start  in  1  start button, level, already debounced
- i_Up_Mvt / i_Down_Mvt / i_Left_Mvt / i_Right_Mvt  in  1 each  move buttons, level, already debounced
- i_Col_Count_Div  in  5  current pixel tile column
- i_Row_Count_Div  in  5  current pixel tile row
- i_Frog_Tile  in  4  bitmap code at (o_Frogger_Y, o_Frogger_X); 0 = wall, 4 = lily pad; valid one clock after the position changes
- o_Frogger_X  out  6  frog tile column
- o_Frogger_Y  out  6  frog tile row
- o_Draw_Frogger  out  1  current pixel tile equals the frog tile
- o_Score  out  7  score, 0..99
- o_Lives  out  2  remaining lives
- o_Game_Active  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, X = c_START_X, Y = c_START_Y, score = 0, lives = 0.
  - Cooldown counter = 0; button edge registers = 0.
  - All outputs low except the X/Y start values.
- Buttons are rising-edge detected using one registered copy of each button. A held button produces one hop only.
- FSM:
  - IDLE: a rising edge on i_Game_Start -> PLAY. On that transition score = 0, lives = c_LIVES, frog at start.
  - PLAY: on any move edge, perform one hop -> COOLDOWN.
    - Priority when several edges occur in the same clock: Up > Down > Left > Right.
    - Up: Y-1, ignored at Y=0. Down: Y+1, ignored at Y=c_GAME_HEIGHT-1.
    - Left: X-1, ignored at X=0. Right: X+1, ignored at X=c_GAME_WIDTH-1.
    - An ignored move is not a hop: state stays PLAY and no cooldown starts.
  - COOLDOWN: counter runs from 0 to c_HOP_DELAY-1, then the next state is decided:
    - CHECK if Y==0;
    - otherwise PLAY.
    - Move edges during COOLDOWN are discarded.
  - CHECK (one clock; i_Frog_Tile is valid by then):
    - Tile 4: score+1 and frog to start. If the new score == c_SCORE_LIMIT -> IDLE (win, score held); else -> PLAY.
    - Any other tile: lives-1 and frog to start. If lives become 0 -> IDLE (score held); else -> PLAY.
- Water and road hazards belong to a future collision block. This block does not kill the frog on those tiles.
- i_Game_Start is ignored in every state other than IDLE.
- o_Draw_Frogger:
  - Combinational.
  - Equals o_Game_Active AND (i_Col_Count_Div == X[4:0]) AND (i_Row_Count_Div == Y[4:0]).
  - Zero latency from the tile counters; position registers update on clock.
- Width rules:
  - The score increments in a 7-bit register and never exceeds c_SCORE_LIMIT.
  - Lives never wrap below 0.
- Reset mid-hop or mid-CHECK: immediate return to the reset values. No pending score or life change survives.

Test Plan:
- Use c_HOP_DELAY = 4 for all scenarios.
1. Reset, then pulse i_Game_Start -> state PLAY, o_Game_Active=1, X=7, Y=12, o_Score=0, o_Lives=3.
2. Hold i_Up_Mvt for 20 clocks -> exactly one hop, Y=11. Further Up edges inside the 4-clock cooldown -> Y stays 11.
3. Frog at X=0, Left edge -> X stays 0 and no cooldown starts. Up and Right edges in the same clock -> Y-1 only, X unchanged.
4. Drive the frog to X=6, Y=0 with i_Frog_Tile=4 -> after CHECK, o_Score=1, X=7, Y=12, state PLAY. Same at X=7 with i_Frog_Tile=0 -> o_Lives=2, score unchanged.
5. Three wall landings -> o_Lives=0, state IDLE, o_Game_Active=0, o_Draw_Frogger=0 everywhere. Preload score 98, then one lily landing -> o_Score=99, state IDLE.
6. Frog at (7,12) with tile counters swept over all tiles -> o_Draw_Frogger=1 only at col 7, row 12. Assert i_Rst_N=0 during COOLDOWN -> all outputs at reset values within the same clock edge window (asynchronous).

Source files
------------

// File: rtl/frog_hop_ctrl.sv
// Frog movement and scoring controller.
// Turns debounced button presses into single-tile hops on the play grid,
// enforces a lockout after every hop, and judges landings on the goal row:
// a lily pad scores a point, anything else costs a life. The frog position,
// score, lives and a per-pixel draw flag feed the top-level game and the
// video/7-segment stages.
module frog_hop_ctrl #(
    parameter int c_GAME_WIDTH  = 14,
    parameter int c_GAME_HEIGHT = 13,
    parameter int c_START_X     = 7,
    parameter int c_START_Y     = 12,
    parameter int c_HOP_DELAY   = 6250000,
    parameter int c_LIVES       = 3,
    parameter int c_SCORE_LIMIT = 99
) (
    input  logic       i_Clk,
    input  logic       i_Rst_N,
    input  logic       i_Game_Start,
    input  logic       i_Up_Mvt,
    input  logic       i_Down_Mvt,
    input  logic       i_Left_Mvt,
    input  logic       i_Right_Mvt,
    input  logic [4:0] i_Col_Count_Div,
    input  logic [4:0] i_Row_Count_Div,
    input  logic [3:0] i_Frog_Tile,
    output logic [5:0] o_Frogger_X,
    output logic [5:0] o_Frogger_Y,
    output logic       o_Draw_Frogger,
    output logic [6:0] o_Score,
    output logic [1:0] o_Lives,
    output logic       o_Game_Active
);

    // Counter only needs to reach c_HOP_DELAY-1; keep at least one bit.
    localparam int CW = (c_HOP_DELAY > 1) ? $clog2(c_HOP_DELAY) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(c_HOP_DELAY - 1);
    localparam logic [5:0] START_X  = 6'(c_START_X);
    localparam logic [5:0] START_Y  = 6'(c_START_Y);
    localparam logic [5:0] LAST_COL = 6'(c_GAME_WIDTH - 1);
    localparam logic [5:0] LAST_ROW = 6'(c_GAME_HEIGHT - 1);
    localparam logic [6:0] LIMIT    = 7'(c_SCORE_LIMIT);
    localparam logic [1:0] LIVES    = 2'(c_LIVES);
    localparam logic [3:0] TILE_LILY = 4'd4;

    // Button vector bit positions.
    localparam int B_START = 0;
    localparam int B_UP    = 1;
    localparam int B_DOWN  = 2;
    localparam int B_LEFT  = 3;
    localparam int B_RIGHT = 4;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        COOLDOWN,
        CHECK
    } state_t;

    state_t          state_reg, state_next;
    logic [5:0]      x_reg, x_next;
    logic [5:0]      y_reg, y_next;
    logic [6:0]      score_reg, score_next;
    logic [1:0]      lives_reg, lives_next;
    logic [CW-1:0]   cnt_reg, cnt_next;

    logic [4:0]      btn_w;
    logic [4:0]      btn_q_reg;
    logic [4:0]      edge_w;

    assign btn_w = {i_Right_Mvt, i_Left_Mvt, i_Down_Mvt, i_Up_Mvt, i_Game_Start};

    // One delayed copy per button; a rising edge is "high now, low last clock".
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_edge
            always_ff @(posedge i_Clk or negedge i_Rst_N) begin
                if (!i_Rst_N) begin
                    btn_q_reg[gi] <= 1'b0;
                end else begin
                    btn_q_reg[gi] <= btn_w[gi];
                end
            end
            assign edge_w[gi] = btn_w[gi] & ~btn_q_reg[gi];
        end
    endgenerate

    // State, position, score, lives and lockout counter registers.
    always_ff @(posedge i_Clk or negedge i_Rst_N) begin
        if (!i_Rst_N) begin
            state_reg <= IDLE;
            x_reg     <= START_X;
            y_reg     <= START_Y;
            score_reg <= '0;
            lives_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            score_reg <= score_next;
            lives_reg <= lives_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: start, hop selection, lockout timing and landing judgement.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        score_next = score_reg;
        lives_next = lives_reg;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (edge_w[B_START]) begin
                    state_next = PLAY;
                    score_next = '0;
                    lives_next = LIVES;
                    x_next     = START_X;
                    y_next     = START_Y;
                end
            end

            PLAY: begin
                // The highest-priority edge picks the move; if that move would
                // leave the grid nothing happens and no lockout starts.
                if (edge_w[B_UP]) begin
                    if (y_reg != 6'd0) begin
                        y_next     = y_reg - 6'd1;
                        state_next = COOLDOWN;
                        cnt_next   = '0;
                    end
                end else if (edge_w[B_DOWN]) begin
                    if (y_reg != LAST_ROW) begin
                        y_next     = y_reg + 6'd1;
                        state_next = COOLDOWN;
                        cnt_next   = '0;
                    end
                end else if (edge_w[B_LEFT]) begin
                    if (x_reg != 6'd0) begin
                        x_next     = x_reg - 6'd1;
                        state_next = COOLDOWN;
                        cnt_next   = '0;
                    end
                end else if (edge_w[B_RIGHT]) begin
                    if (x_reg != LAST_COL) begin
                        x_next     = x_reg + 6'd1;
                        state_next = COOLDOWN;
                        cnt_next   = '0;
                    end
                end
            end

            COOLDOWN: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next   = '0;
                    state_next = (y_reg == 6'd0) ? CHECK : PLAY;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end

            CHECK: begin
                x_next = START_X;
                y_next = START_Y;
                if (i_Frog_Tile == TILE_LILY) begin
                    if (score_reg < LIMIT) begin
                        score_next = score_reg + 7'd1;
                    end
                    state_next = (score_next == LIMIT) ? IDLE : PLAY;
                end else begin
                    if (lives_reg != 2'd0) begin
                        lives_next = lives_reg - 2'd1;
                    end
                    state_next = (lives_next == 2'd0) ? IDLE : PLAY;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_Frogger_X    = x_reg;
    assign o_Frogger_Y    = y_reg;
    assign o_Score        = score_reg;
    assign o_Lives        = lives_reg;
    assign o_Game_Active  = (state_reg != IDLE);
    assign o_Draw_Frogger = o_Game_Active
                            && (i_Col_Count_Div == x_reg[4:0])
                            && (i_Row_Count_Div == y_reg[4:0]);

endmodule

// File: tb/tb_frog_hop_ctrl.sv
// Testbench for frog_hop_ctrl with a short hop lockout.
// The reference model works in terms of game rules and clock-edge numbers:
// when the next hop may be accepted and on which edge a landing is judged.
module tb_frog_hop_ctrl;

    localparam int D = 4;
    localparam logic [4:0] B_START = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [4:0] col = 5'd0, row = 5'd0;
    logic [3:0] tile = 4'd0;
    logic [5:0] frog_x, frog_y;
    logic       draw, active;
    logic [6:0] score;
    logic [1:0] lives;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state
    bit m_active;
    int m_x, m_y, m_score, m_lives;
    int m_ready;     // first edge number on which a move edge is accepted
    int m_check;     // edge number on which a landing is judged (-1: none)
    logic p_start, p_up, p_down, p_left, p_right;

    frog_hop_ctrl #(
        .c_HOP_DELAY(D)
    ) dut (
        .i_Clk          (clk),
        .i_Rst_N        (rst_n),
        .i_Game_Start   (start),
        .i_Up_Mvt       (up),
        .i_Down_Mvt     (down),
        .i_Left_Mvt     (left),
        .i_Right_Mvt    (right),
        .i_Col_Count_Div(col),
        .i_Row_Count_Div(row),
        .i_Frog_Tile    (tile),
        .o_Frogger_X    (frog_x),
        .o_Frogger_Y    (frog_y),
        .o_Draw_Frogger (draw),
        .o_Score        (score),
        .o_Lives        (lives),
        .o_Game_Active  (active)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_active = 1'b0;
        m_x = 7; m_y = 12; m_score = 0; m_lives = 0;
        m_ready = 0; m_check = -1;
        p_start = 1'b0; p_up = 1'b0; p_down = 1'b0; p_left = 1'b0; p_right = 1'b0;
    endtask

    // Game rules applied to the inputs presented for the coming edge.
    task automatic model_step();
        int  n;
        bit  moved;
        logic es, eu, ed, el, er;
        n  = cyc + 1;
        es = start & ~p_start;
        eu = up & ~p_up;
        ed = down & ~p_down;
        el = left & ~p_left;
        er = right & ~p_right;
        moved = 1'b0;
        if (!m_active) begin
            if (es) begin
                m_active = 1'b1; m_score = 0; m_lives = 3;
                m_x = 7; m_y = 12; m_ready = n + 1; m_check = -1;
            end
        end else if (m_check == n) begin
            m_check = -1; m_x = 7; m_y = 12; m_ready = n + 1;
            if (tile == 4'd4) begin
                m_score++;
                if (m_score == 99) m_active = 1'b0;
            end else begin
                m_lives--;
                if (m_lives == 0) m_active = 1'b0;
            end
        end else if (m_check < 0 && n >= m_ready) begin
            if (eu)      begin if (m_y > 0)  begin m_y--; moved = 1'b1; end end
            else if (ed) begin if (m_y < 12) begin m_y++; moved = 1'b1; end end
            else if (el) begin if (m_x > 0)  begin m_x--; moved = 1'b1; end end
            else if (er) begin if (m_x < 13) begin m_x++; moved = 1'b1; end end
            if (moved) begin
                m_ready = n + D + 1;
                if (m_y == 0) begin
                    m_check = n + D + 1;
                    m_ready = n + D + 2;
                end
            end
        end
        p_start = start; p_up = up; p_down = down; p_left = left; p_right = right;
    endtask

    task automatic tick();
        if (!rst_n) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Let the model-predicted lockout / landing judgement run out.
    task automatic wait_ready();
        int guard;
        guard = 0;
        while (m_active && ((cyc + 1 < m_ready) || (m_check >= 0)) && guard < 64) begin
            tick();
            guard++;
        end
        if (guard >= 64) begin
            checks++; failures++;
            $display("FAIL wait_ready bound expired at cycle %0d", cyc);
        end
    endtask

    task automatic press(input logic [4:0] mask, input bit wait_after);
        {start, up, down, left, right} = mask;
        tick();
        {start, up, down, left, right} = 5'b0;
        if (wait_after) wait_ready();
    endtask

    task automatic reset_start();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        press(B_START, 1'b1);
    endtask

    task automatic land(input logic [3:0] tile_v);
        tile = tile_v;
        repeat (12) press(B_UP, 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        col = 5'd7; row = 5'd12;
        tick(); tick();
        checks++; if (frog_x !== 6'd7)  begin failures++; $display("FAIL reset_x got=%0d exp=7", frog_x); end
        checks++; if (frog_y !== 6'd12) begin failures++; $display("FAIL reset_y got=%0d exp=12", frog_y); end
        checks++; if ({score, lives, active, draw} !== 11'd0)
            begin failures++; $display("FAIL reset_outs score=%0d lives=%0d act=%0b draw=%0b exp all 0", score, lives, active, draw); end
        rst_n = 1'b1;
        tick();
        $display("test_reset done checks=%0d", checks);
    endtask

    task automatic test_start();
        press(B_START, 1'b1);
        checks++; if (active !== 1'b1) begin failures++; $display("FAIL start_active got=%0b exp=1", active); end
        checks++; if (frog_x !== 6'd7 || frog_y !== 6'd12)
            begin failures++; $display("FAIL start_pos got=(%0d,%0d) exp=(7,12)", frog_x, frog_y); end
        checks++; if (score !== 7'd0 || lives !== 2'd3)
            begin failures++; $display("FAIL start_score_lives got=%0d/%0d exp=0/3", score, lives); end
        $display("test_start done checks=%0d", checks);
    endtask

    task automatic test_hold_up();
        up = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++; if (frog_y !== 6'(m_y))
                begin failures++; $display("FAIL hold_up_y cyc=%0d got=%0d exp=%0d", i, frog_y, m_y); end
        end
        checks++; if (frog_y !== 6'd11) begin failures++; $display("FAIL hold_up_final got=%0d exp=11", frog_y); end
        up = 1'b0; tick();
        // hop, then an edge inside the lockout (discarded), then one just after it
        press(B_UP, 1'b0);                      // edge n: y 10
        repeat (2) tick();
        up = 1'b1; tick();                      // edge n+3: inside lockout
        checks++; if (frog_y !== 6'd10) begin failures++; $display("FAIL lockout_discard got=%0d exp=10", frog_y); end
        up = 1'b0; tick();                      // edge n+4: last lockout clock
        up = 1'b1; tick();                      // edge n+5: accepted
        up = 1'b0;
        checks++; if (frog_y !== 6'd9) begin failures++; $display("FAIL lockout_end_hop got=%0d exp=9", frog_y); end
        checks++; if (frog_y !== 6'(m_y)) begin failures++; $display("FAIL lockout_model got=%0d exp=%0d", frog_y, m_y); end
        wait_ready();
        $display("test_hold_up done checks=%0d", checks);
    endtask

    task automatic test_boundaries();
        reset_start();
        press(B_DOWN, 1'b0);                    // ignored at bottom row
        checks++; if (frog_y !== 6'd12) begin failures++; $display("FAIL down_bottom got=%0d exp=12", frog_y); end
        repeat (7) press(B_LEFT, 1'b1);
        checks++; if (frog_x !== 6'd0) begin failures++; $display("FAIL walk_left got=%0d exp=0", frog_x); end
        press(B_LEFT, 1'b0);                    // ignored: no lockout
        checks++; if (frog_x !== 6'd0) begin failures++; $display("FAIL left_edge got=%0d exp=0", frog_x); end
        press(B_UP, 1'b0);                      // must hop on the very next edge
        checks++; if (frog_y !== 6'd11) begin failures++; $display("FAIL no_cooldown got=%0d exp=11", frog_y); end
        wait_ready();
        press(B_UP | B_RIGHT, 1'b1);
        checks++; if (frog_y !== 6'd10 || frog_x !== 6'd0)
            begin failures++; $display("FAIL up_right_prio got=(%0d,%0d) exp=(0,10)", frog_x, frog_y); end
        press(B_LEFT | B_RIGHT | B_DOWN, 1'b1);
        checks++; if (frog_y !== 6'd11 || frog_x !== 6'd0)
            begin failures++; $display("FAIL down_prio got=(%0d,%0d) exp=(0,11)", frog_x, frog_y); end
        repeat (14) press(B_RIGHT, 1'b1);
        checks++; if (frog_x !== 6'd13) begin failures++; $display("FAIL right_edge got=%0d exp=13", frog_x); end
        $display("test_boundaries done checks=%0d", checks);
    endtask

    task automatic test_landing();
        reset_start();
        press(B_LEFT, 1'b1);
        land(4'd4);
        checks++; if (score !== 7'd1) begin failures++; $display("FAIL lily_score got=%0d exp=1", score); end
        checks++; if (frog_x !== 6'd7 || frog_y !== 6'd12 || active !== 1'b1)
            begin failures++; $display("FAIL lily_respawn got=(%0d,%0d) act=%0b exp=(7,12) 1", frog_x, frog_y, active); end
        land(4'd0);
        checks++; if (lives !== 2'd2 || score !== 7'd1)
            begin failures++; $display("FAIL wall_life got lives=%0d score=%0d exp=2/1", lives, score); end
        press(B_START, 1'b1);                   // ignored while playing
        checks++; if (score !== 7'd1 || lives !== 2'd2)
            begin failures++; $display("FAIL start_ignored got=%0d/%0d exp=1/2", score, lives); end
        $display("test_landing done checks=%0d", checks);
    endtask

    task automatic test_game_over_and_win();
        reset_start();
        repeat (3) land(4'd0);
        checks++; if (lives !== 2'd0 || active !== 1'b0)
            begin failures++; $display("FAIL game_over got lives=%0d act=%0b exp=0/0", lives, active); end
        for (int c = 0; c < 14; c++) begin
            for (int r = 0; r < 13; r++) begin
                col = 5'(c); row = 5'(r); #1;
                checks++; if (draw !== 1'b0)
                    begin failures++; $display("FAIL idle_draw at=(%0d,%0d) got=%0b exp=0", c, r, draw); end
            end
        end
        press(B_START, 1'b1);
        repeat (98) land(4'd4);
        checks++; if (score !== 7'd98 || active !== 1'b1)
            begin failures++; $display("FAIL preload got score=%0d act=%0b exp=98/1", score, active); end
        land(4'd4);
        checks++; if (score !== 7'd99 || active !== 1'b0 || lives !== 2'd3)
            begin failures++; $display("FAIL win got score=%0d act=%0b lives=%0d exp=99/0/3", score, active, lives); end
        repeat (3) tick();
        checks++; if (score !== 7'd99) begin failures++; $display("FAIL win_hold got=%0d exp=99", score); end
        $display("test_game_over_and_win done checks=%0d", checks);
    endtask

    task automatic test_draw_and_async_reset();
        reset_start();
        for (int c = 0; c < 14; c++) begin
            for (int r = 0; r < 13; r++) begin
                col = 5'(c); row = 5'(r); #1;
                checks++; if (draw !== ((c == 7) && (r == 12)))
                    begin failures++; $display("FAIL draw_sweep at=(%0d,%0d) got=%0b", c, r, draw); end
            end
        end
        col = 5'd7; row = 5'd11;
        press(B_UP, 1'b0);
        tick();
        rst_n = 1'b0;                           // mid-lockout, between edges
        #1;
        checks++; if (frog_y !== 6'd12 || frog_x !== 6'd7 || {score, lives, active, draw} !== 11'd0)
            begin failures++; $display("FAIL async_reset got=(%0d,%0d) s=%0d l=%0d a=%0b d=%0b", frog_x, frog_y, score, lives, active, draw); end
        model_reset();
        #2;
        rst_n = 1'b1;
        tick();
        checks++; if (active !== 1'b0 || frog_y !== 6'd12)
            begin failures++; $display("FAIL post_reset got act=%0b y=%0d exp=0/12", active, frog_y); end
        $display("test_draw_and_async_reset done checks=%0d", checks);
    endtask

    task automatic test_random();
        int pick;
        bit exp_draw;
        reset_start();
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            up    = 1'($urandom_range(0, 1));
            down  = ($urandom_range(0, 7) == 0);
            left  = ($urandom_range(0, 3) == 0);
            right = ($urandom_range(0, 3) == 0);
            pick  = $urandom_range(0, 7);
            tile  = (pick < 5) ? 4'd4 : ((pick == 5) ? 4'd0 : 4'(pick));
            col   = $urandom_range(0, 1) ? 5'(m_x) : 5'($urandom_range(0, 31));
            row   = $urandom_range(0, 1) ? 5'(m_y) : 5'($urandom_range(0, 31));
            tick();
            exp_draw = m_active && (int'(col) == m_x) && (int'(row) == m_y);
            checks++; if (frog_x !== 6'(m_x) || frog_y !== 6'(m_y))
                begin failures++; $display("FAIL rnd_pos i=%0d got=(%0d,%0d) exp=(%0d,%0d)", i, frog_x, frog_y, m_x, m_y); end
            checks++; if (score !== 7'(m_score) || lives !== 2'(m_lives))
                begin failures++; $display("FAIL rnd_score_lives i=%0d got=%0d/%0d exp=%0d/%0d", i, score, lives, m_score, m_lives); end
            checks++; if (active !== m_active || draw !== exp_draw)
                begin failures++; $display("FAIL rnd_active_draw i=%0d got=%0b/%0b exp=%0b/%0b", i, active, draw, m_active, exp_draw); end
        end
        {start, up, down, left, right} = 5'b0;
        $display("test_random done checks=%0d", checks);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_hold_up();
        test_boundaries();
        test_landing();
        test_game_over_and_win();
        test_draw_and_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
